// File: rtl/mips_muldiv_if.sv
// Request/result bundle between the ALU (master) and the HI/LO multiply/divide unit (slave).
// start/busy/done: start is taken only while busy=0; done pulses one cycle when HI/LO are written.
interface mips_muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one radix-2 step per cycle, sign fix-up in FIX.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational product.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    mips_muldiv_if.slave     bus,
    output logic [1:0]       dbg_state
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [WIDTH-1:0]   ZERO   = '0;
    localparam logic [2*WIDTH-1:0] ZERO2  = '0;
    localparam logic [CW-1:0]      LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_1  = CW'(1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   a_orig;
    logic [2*WIDTH-1:0] acc;
    logic               neg_res;
    logic               neg_rem;
    logic               b_zero;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               dbz_q;

    // Operand magnitudes at the request edge; op[0]=0 selects the signed variants.
    logic               in_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    always_comb begin
        in_signed = ~bus.op[0];
        abs_a     = (in_signed && bus.a[WIDTH-1]) ? (ZERO - bus.a) : bus.a;
        abs_b     = (in_signed && bus.b[WIDTH-1]) ? (ZERO - bus.b) : bus.b;
    end

    // Multiply step: acc = {partial product, remaining multiplier bits}, shifted right each cycle.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {1'b0, ZERO});
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // Restoring divide step: acc = {remainder, dividend/quotient}, shifted left each cycle.
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = rem_sh - {1'b0, mag_b};
        if (div_diff[WIDTH])
            div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod_mag = {ZERO, mag_a} * {ZERO, mag_b};
`else
        prod_mag = acc;
`endif
        prod_fix = neg_res ? (ZERO2 - prod_mag) : prod_mag;
        quot_fix = neg_res ? (ZERO - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? (ZERO - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_q    <= 2'b00;
            mag_a   <= '0;
            mag_b   <= '0;
            a_orig  <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.wr_hi) hi_q <= bus.wdata;
                    if (bus.wr_lo) lo_q <= bus.wdata;
                    if (bus.start) begin
                        op_q    <= bus.op;
                        mag_a   <= abs_a;
                        mag_b   <= abs_b;
                        a_orig  <= bus.a;
                        b_zero  <= (bus.b == ZERO);
                        neg_res <= in_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_rem <= in_signed && bus.a[WIDTH-1];
                        cnt     <= '0;
                        dbz_q   <= 1'b0;
                        acc     <= bus.op[1] ? {ZERO, abs_a} : {ZERO, abs_b};
`ifdef MULDIV_FAST_MUL_EN
                        state   <= bus.op[1] ? S_RUN : S_FIX;
`else
                        state   <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    acc <= op_q[1] ? div_next : mul_next;
                    cnt <= cnt + CNT_1;
                    if (cnt == LAST) state <= S_FIX;
                end
                S_FIX: begin
                    if (op_q[1]) begin
                        if (b_zero) begin
                            lo_q  <= '1;
                            hi_q  <= a_orig;
                            dbz_q <= 1'b1;
                        end else begin
                            lo_q  <= quot_fix;
                            hi_q  <= rem_fix;
                        end
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: latency, sign handling, divide-by-zero, MTHI/MTLO and reset abort.
module tb_mips_muldiv_unit;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam int DIV_LAT = 33;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    mips_muldiv_if #(.WIDTH(32)) bus ();

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the request is sampled at the following posedge (E0).
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.op    = 2'($urandom_range(0, 3));
        check("accept_busy", bus.busy, 1);
        check("accept_done_low", bus.done, 0);
        check("accept_dbz_clear", bus.div_by_zero, 0);
    endtask

    task automatic wait_done(input int exp_lat, input bit inject, input bit exp_dbz);
        int          k;
        logic [63:0] e;
        k = 0;
        while (!bus.done && k < 100) begin
            if (inject && k == 10) begin
                bus.start = 1'b1;
                bus.op    = OP_DIVU;
                bus.a     = 32'd9;
                bus.b     = 32'd3;
                bus.wr_hi = 1'b1;
                bus.wdata = 32'h0000DEAD;
            end
            if (inject && k == 11) begin
                bus.start = 1'b0;
                bus.wr_hi = 1'b0;
            end
            if (k == 5 || k == 20) begin
                check("hold_hi", bus.hi, model_hi);
                check("hold_lo", bus.lo, model_lo);
            end
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        check("latency", k, exp_lat);
        check("done_busy_low", bus.busy, 0);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        check("hi", bus.hi, e[63:32]);
        check("lo", bus.lo, e[31:0]);
        check("div_by_zero", bus.div_by_zero, exp_dbz);
        model_hi = e[63:32];
        model_lo = e[31:0];
    endtask

    initial begin
        int n_done;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wdata = '0;
        reset     = 1'b0;
        model_hi  = '0;
        model_lo  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b1;
        @(negedge clk);

        // MULTU then MULT back-to-back, the second start raised in the done cycle.
        exp_q.push_back(64'hFFFFFFFE_00000001);
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(MUL_LAT, 1'b0, 1'b0);
        exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
        start_op(OP_MULT, 32'hFFFFFFFE, 32'd3);
        wait_done(MUL_LAT, 1'b0, 1'b0);

        exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
        start_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(DIV_LAT, 1'b0, 1'b0);
        exp_q.push_back(64'h00000001_00000003);
        start_op(OP_DIVU, 32'd7, 32'd2);
        wait_done(DIV_LAT, 1'b0, 1'b0);
        exp_q.push_back(64'h00000000_80000000);
        start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(DIV_LAT, 1'b0, 1'b0);

        // Divide by zero: flag held, then cleared by the next accepted start.
        exp_q.push_back(64'h00000005_FFFFFFFF);
        start_op(OP_DIVU, 32'd5, 32'd0);
        wait_done(DIV_LAT, 1'b0, 1'b1);
        @(negedge clk);
        check("dbz_hold", bus.div_by_zero, 1);
        exp_q.push_back(64'hFFFFFFF9_FFFFFFFF);
        start_op(OP_DIV, 32'hFFFFFFF9, 32'd0);
        wait_done(DIV_LAT, 1'b0, 1'b1);
        @(negedge clk);

        // start and wr_hi raised mid-run must be dropped.
        exp_q.push_back(64'h00000000_0000000C);
        start_op(OP_MULTU, 32'd3, 32'd4);
        wait_done(MUL_LAT, 1'b1, 1'b0);
        @(negedge clk);
        check("ignored_start_idle", bus.busy, 0);
        check("ignored_wr_hi", bus.hi, 0);
        exp_q.push_back(64'h00000002_0000000E);
        start_op(OP_DIVU, 32'd100, 32'd7);
        wait_done(DIV_LAT, 1'b1, 1'b0);
        @(negedge clk);
        check("ignored_start_idle2", bus.busy, 0);

        // MTLO alone, then MTHI+MTLO together.
        bus.wr_lo = 1'b1;
        bus.wdata = 32'h00001234;
        @(negedge clk);
        bus.wr_lo = 1'b0;
        check("mtlo_lo", bus.lo, 32'h00001234);
        check("mtlo_hi_kept", bus.hi, 32'h00000002);
        bus.wr_hi = 1'b1;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'h0000CAFE;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        check("mt_both_hi", bus.hi, 32'h0000CAFE);
        check("mt_both_lo", bus.lo, 32'h0000CAFE);

        // MTLO together with start: applied now, replaced by the result.
        model_hi  = 32'h0000CAFE;
        model_lo  = 32'hAAAA5555;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'hAAAA5555;
        exp_q.push_back(64'h00000001_00000003);
        start_op(OP_DIVU, 32'd7, 32'd2);
        check("wr_with_start_lo", bus.lo, 32'hAAAA5555);
        wait_done(DIV_LAT, 1'b0, 1'b0);
        @(negedge clk);

        // Reset at iteration 10 of a DIV aborts it.
        start_op(OP_DIV, 32'd1000, 32'd7);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        reset  = 1'b1;
        n_done = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        model_hi = '0;
        model_lo = '0;

        exp_q.push_back(64'hFFFFFFFF_FFFFFFDD);
        start_op(OP_MULT, 32'd7, 32'hFFFFFFFB);
        wait_done(MUL_LAT, 1'b0, 1'b0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
